switch_debounce: RTL and testbench
==================================

// Module: switch_debounce
// PURPOSE
//   Conditions the raw slide-switch inputs SW[1:0] before they reach the Nios
//   switch PIO (switch_external_connection_export).
//   - Synchronises each bit into the MAX10_CLK1_50 domain and debounces it with
//     a per-bit stability counter.
//   - Emits single-cycle rise/fall pulses for each bit.
//   - Sits between the board pins and nios_setup_v2 in the top level.
// PARAMETERS
//   WIDTH            2        number of switch bits handled independently
//   SYNC_STAGES      2        flip-flops in each input synchroniser chain (>=2)
//   DEBOUNCE_CYCLES  500000   cycles a new level must hold before acceptance
//                             (10 ms at 50 MHz; >=2)
// PORTS
//   MAX10_CLK1_50  in   1      50 MHz system clock; all logic on rising edge
//   reset          in   1      synchronous, active-high reset
//   sw_in          in   WIDTH  raw asynchronous switch levels from the pins
//   sw_out         out  WIDTH  debounced levels; drives the PIO export
//   sw_rise        out  WIDTH  1-cycle pulse when sw_out[i] goes 0->1
//   sw_fall        out  WIDTH  1-cycle pulse when sw_out[i] goes 1->0
//   changed        out  1      OR of all sw_rise | sw_fall bits (same cycle)
//   irq            out  1      sticky change flag (see CONFIGURATION)
//   irq_ack        in   1      clears irq (see CONFIGURATION)
// BEHAVIOUR
//   Reset (reset=1 at a clock edge):
//   - Synchroniser flops, counters, sw_out, sw_rise, sw_fall, changed and irq
//     all clear to 0.
//   - A switch already high at reset release therefore produces one sw_rise
//     after the normal latency. This is required behaviour.
//   Per bit i (fully independent, no cross-bit interaction):
//   - s[i] = output of the SYNC_STAGES chain; lags sw_in[i] by SYNC_STAGES cycles.
//   - Counter width is $clog2(DEBOUNCE_CYCLES), unsigned.
//   - s[i]==sw_out[i]: counter <= 0.
//   - s[i]!=sw_out[i] and counter<DEBOUNCE_CYCLES-1: counter <= counter+1.
//   - s[i]!=sw_out[i] and counter==DEBOUNCE_CYCLES-1:
//       sw_out[i] <= s[i]; counter <= 0; sw_rise[i]/sw_fall[i] <= 1 per
//       direction on the same edge.
//   - Pulses are registered and high for exactly one cycle, coincident with
//     the first cycle of the new sw_out value.
//   - Latency: a clean step on sw_in reaches sw_out exactly
//     SYNC_STAGES + DEBOUNCE_CYCLES cycles later.
//   - Glitch or bounce: any return of s[i] to sw_out[i] before the terminal
//     count clears the counter. There is no output change and no pulse.
//   - Counter never wraps; the terminal compare precludes overflow.
//   - Simultaneous edges on several bits: each bit pulses independently in the
//     same cycle; changed is asserted once.
//   - Reset mid-count: the count is discarded, sw_out returns to 0 and no pulse
//     is emitted on the reset edge.
// CONFIGURATION
//   Macro SWITCH_DEBOUNCE_IRQ_EN.
//   Defined:
//     - irq <= 1 on any cycle where changed=1.
//     - irq <= 0 when irq_ack=1 and changed=0.
//     - changed and irq_ack in the same cycle: set wins, irq stays 1.
//     - Reset value is 0.
//   Not defined:
//     - irq is tied to constant 0; irq_ack is ignored; no irq flop is built.
//     - Ports remain present so the top level is unchanged.
// TESTING (bench uses WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=8)
//   1. Hold reset 3 cycles with sw_in=2'b11, release
//        -> all outputs 0 during reset
//        -> sw_out=2'b11 and sw_rise=2'b11 for 1 cycle, 10 cycles after release.
//   2. sw_in[0] 0->1 clean step
//        -> sw_out[0]=1 exactly 10 cycles later
//        -> sw_rise[0]=1 for one cycle; changed=1 that cycle; sw_fall=0.
//   3. sw_in[1] bounces 1,0,1,0 every 3 cycles, then holds 1
//        -> no pulse during bouncing
//        -> sw_out[1]=1 exactly 10 cycles after the final 0->1.
//   4. sw_out=2'b11; sw_in drops to 2'b00 for 5 cycles, then returns to 2'b11
//        -> sw_out stays 2'b11; no sw_fall pulse.
//   5. Assert reset 4 cycles into a pending 0->1 count, release with input still high
//        -> sw_out stays 0 through reset
//        -> rise occurs 10 cycles after release.
//   6. IRQ_EN defined: change pulse, then irq_ack asserted in the same cycle as the next pulse
//        -> irq=1 the cycle after the first pulse; stays 1 after the collision
//        -> clears the cycle after a lone irq_ack.
//      IRQ_EN undefined: irq=0 throughout.

Source files
------------

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: bundles the switch-side signals of switch_debounce.
// The master modport is the debouncer itself (it produces the conditioned
// levels, pulses and interrupt); the slave modport is whatever consumes
// them (the PIO export / top level) and drives the raw pins and irq_ack.
interface switch_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             changed;
    logic             irq;
    logic             irq_ack;

    modport master (
        input  sw_in,
        input  irq_ack,
        output sw_out,
        output sw_rise,
        output sw_fall,
        output changed,
        output irq
    );

    modport slave (
        output sw_in,
        output irq_ack,
        input  sw_out,
        input  sw_rise,
        input  sw_fall,
        input  changed,
        input  irq
    );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: synchronises and debounces the raw slide switches, and
// produces one-cycle rise/fall pulses plus a combined "changed" strobe.
// Each bit is handled completely independently of the others.
//
// Optional feature: define SWITCH_DEBOUNCE_IRQ_EN to build a sticky irq flag
// that is set by "changed" and cleared by irq_ack (set wins on a collision).
// Without the macro irq is tied low and irq_ack is ignored; the ports stay so
// the top level does not change.
module switch_debounce #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 reset,
    switch_debounce_if.master    bus
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    // Terminal count: the counter never goes past this value, so it can
    // never wrap even when DEBOUNCE_CYCLES is an exact power of two.
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] syncOut;

    logic [CW-1:0]    count_q [WIDTH];
    logic [CW-1:0]    count_d [WIDTH];
    logic [WIDTH-1:0] swOut_q, swOut_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    assign syncOut = sync_q[SYNC_STAGES-1];

    // Synchroniser chain bringing the asynchronous pins into the clock domain.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.sw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-bit stability counter: a differing level must persist up to the
    // terminal count before it is accepted; any return to the old level
    // restarts the count, which is what swallows bounce and glitches.
    always_comb begin
        swOut_d = swOut_q;
        rise_d  = '0;
        fall_d  = '0;
        count_d = count_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (syncOut[i] == swOut_q[i]) begin
                count_d[i] = '0;
            end else if (count_q[i] == TERM) begin
                swOut_d[i] = syncOut[i];
                count_d[i] = '0;
                rise_d[i]  = syncOut[i];
                fall_d[i]  = ~syncOut[i];
            end else begin
                count_d[i] = count_q[i] + 1'b1;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Debounced state and registered pulses; pulses land in the same cycle
    // as the first cycle of the new debounced level.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= '0;
            end
            swOut_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            swOut_q   <= swOut_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.sw_out  = swOut_q;
    assign bus.sw_rise = rise_q;
    assign bus.sw_fall = fall_q;
    assign bus.changed = changed_q;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: any change sets it, a lone acknowledge clears it,
    // and a change arriving together with an acknowledge keeps it set.
    always_comb begin
        irq_d = irq_q;
        if (changed_q) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt flag register.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    logic unusedIrqAck;

    assign bus.irq     = 1'b0;
    assign unusedIrqAck = bus.irq_ack;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed self-checking bench for switch_debounce with
// WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, so a clean step on sw_in shows
// up on sw_out exactly 10 clock edges later.
module tb_switch_debounce;
    localparam int WIDTH   = 2;
    localparam int LATENCY = 10;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    localparam logic IRQ_BUILT = 1'b1;
`else
    localparam logic IRQ_BUILT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   nChecks;
    int   nBad;

    switch_debounce_if #(.WIDTH(WIDTH)) swIf ();

    switch_debounce #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset        (reset),
        .bus          (swIf.master)
    );

    // 100 MHz bench clock; the period is irrelevant, only edge counts matter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the inputs; they are applied 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [1:0] swIn, input logic rst, input logic ack);
        swIf.sw_in   = swIn;
        reset        = rst;
        swIf.irq_ack = ack;
    endtask

    // Advance one rising edge and settle just past it before sampling.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Step through a full debounce latency after an input step: the old level
    // must hold with no pulses for LATENCY-1 edges, the new level and its
    // pulses appear on edge LATENCY, and the pulses are gone one edge later.
    task automatic waitTransition(input string tag, input logic [1:0] oldOut,
                                  input logic [1:0] newOut);
        logic [1:0] expRise;
        logic [1:0] expFall;
        expRise = newOut & ~oldOut;
        expFall = oldOut & ~newOut;
        for (int k = 1; k < LATENCY; k++) begin
            stepCycle();
            checkOutput({tag, "_hold_out"}, 32'(swIf.sw_out), 32'(oldOut));
            checkOutput({tag, "_hold_pulse"}, 32'({swIf.sw_rise, swIf.sw_fall}), 32'd0);
        end
        stepCycle();
        checkOutput({tag, "_out"}, 32'(swIf.sw_out), 32'(newOut));
        checkOutput({tag, "_rise"}, 32'(swIf.sw_rise), 32'(expRise));
        checkOutput({tag, "_fall"}, 32'(swIf.sw_fall), 32'(expFall));
        checkOutput({tag, "_changed"}, 32'(swIf.changed), 32'(|(expRise | expFall)));
        stepCycle();
        checkOutput({tag, "_after_out"}, 32'(swIf.sw_out), 32'(newOut));
        checkOutput({tag, "_after_pulse"},
                    32'({swIf.sw_rise, swIf.sw_fall, swIf.changed}), 32'd0);
    endtask

    initial begin
        nChecks = 0;
        nBad    = 0;

        // Test 1: reset with both switches already high, then release.
        applyStimulus(2'b11, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("reset_outputs",
                        32'({swIf.sw_out, swIf.sw_rise, swIf.sw_fall, swIf.changed, swIf.irq}),
                        32'd0);
        end
        applyStimulus(2'b11, 1'b0, 1'b0);
        waitTransition("t1_release", 2'b00, 2'b11);

        // Test 2: bring bit 0 low, then a clean 0->1 step on bit 0.
        applyStimulus(2'b10, 1'b0, 1'b0);
        waitTransition("t2_fall0", 2'b11, 2'b10);
        applyStimulus(2'b11, 1'b0, 1'b0);
        waitTransition("t2_rise0", 2'b10, 2'b11);

        // Test 3: bring bit 1 low, bounce it every 3 cycles, then hold high.
        applyStimulus(2'b01, 1'b0, 1'b0);
        waitTransition("t3_fall1", 2'b11, 2'b01);
        for (int b = 0; b < 4; b++) begin
            applyStimulus((b % 2 == 0) ? 2'b11 : 2'b01, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                stepCycle();
                checkOutput("t3_bounce_out", 32'(swIf.sw_out), 32'h1);
                checkOutput("t3_bounce_pulse",
                            32'({swIf.sw_rise, swIf.sw_fall, swIf.changed}), 32'd0);
            end
        end
        applyStimulus(2'b11, 1'b0, 1'b0);
        waitTransition("t3_rise1", 2'b01, 2'b11);

        // Test 4: a 5-cycle drop to 00 is too short to be accepted.
        applyStimulus(2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            if (k == 5) applyStimulus(2'b11, 1'b0, 1'b0);
            stepCycle();
            checkOutput("t4_glitch_out", 32'(swIf.sw_out), 32'h3);
            checkOutput("t4_glitch_pulse",
                        32'({swIf.sw_rise, swIf.sw_fall, swIf.changed}), 32'd0);
        end

        // Test 5: reset in the middle of a pending rise.
        applyStimulus(2'b00, 1'b0, 1'b0);
        waitTransition("t5_fall", 2'b11, 2'b00);
        applyStimulus(2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkOutput("t5_pending_out", 32'(swIf.sw_out), 32'h0);
        end
        applyStimulus(2'b11, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            stepCycle();
            checkOutput("t5_reset_outputs",
                        32'({swIf.sw_out, swIf.sw_rise, swIf.sw_fall, swIf.changed, swIf.irq}),
                        32'd0);
        end
        applyStimulus(2'b11, 1'b0, 1'b0);
        waitTransition("t5_release", 2'b00, 2'b11);

        // Test 6: sticky irq, lone acknowledge, and set-wins collision.
        checkOutput("t6_irq_after_rise", 32'(swIf.irq), 32'(IRQ_BUILT));
        applyStimulus(2'b11, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t6_irq_lone_ack", 32'(swIf.irq), 32'd0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        waitTransition("t6_pulseA", 2'b11, 2'b10);
        checkOutput("t6_irq_set", 32'(swIf.irq), 32'(IRQ_BUILT));
        stepCycle();
        checkOutput("t6_irq_sticky", 32'(swIf.irq), 32'(IRQ_BUILT));
        applyStimulus(2'b00, 1'b0, 1'b0);
        for (int k = 0; k < LATENCY; k++) begin
            stepCycle();
        end
        checkOutput("t6_pulseB_fall", 32'(swIf.sw_fall), 32'h2);
        checkOutput("t6_pulseB_changed", 32'(swIf.changed), 32'h1);
        applyStimulus(2'b00, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t6_irq_collision", 32'(swIf.irq), 32'(IRQ_BUILT));
        applyStimulus(2'b00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t6_irq_hold", 32'(swIf.irq), 32'(IRQ_BUILT));
        applyStimulus(2'b00, 1'b0, 1'b1);
        stepCycle();
        checkOutput("t6_irq_cleared", 32'(swIf.irq), 32'd0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t6_irq_stays_clear", 32'(swIf.irq), 32'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end
endmodule
